alu_issue_arbiter: RTL and testbench
====================================

ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of reservation-station requesters sharing the single ALU (legal range 2..8).
REQ-002 Parameter TAG_W, default 6, is the ROB tag width.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 flush  in  1  pipeline flush (mispredict/exception).
REQ-006 req_valid  in  NUM_REQ  per-requester instruction valid.
REQ-007 req_ready  out  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
REQ-008 req_opcode / req_funct3 / req_funct7  in  NUM_REQ*7 / NUM_REQ*3 / NUM_REQ*7  packed per-requester decode fields, requester i at slice i.
REQ-009 req_val_a / req_val_b  in  NUM_REQ*32 each  packed operands (rs1/PC, rs2/immediate).
REQ-010 req_tag  in  NUM_REQ*TAG_W  packed destination ROB tags.
REQ-011 alu_opcode, alu_funct3, alu_funct7, alu_val_a, alu_val_b  out  7, 3, 7, 32, 32  drive the ALU's Val_A/Val_B/opcode/funct3/funct7 inputs.
REQ-012 alu_result  in  32  ALU_Result; alu_zero  in  1  Zero_Flag.
REQ-013 cdb_valid  out  1, cdb_ready  in  1, cdb_tag  out  TAG_W, cdb_result  out  32, cdb_zero  out  1  result broadcast to the common data bus.

Function
REQ-014 The block SHALL hold a one-entry result register with states EMPTY (cdb_valid=0) and FULL (cdb_valid=1).
REQ-015 Issue is permitted in a cycle iff flush=0 and (state EMPTY, or state FULL with cdb_ready=1).
REQ-016 When issue is permitted and at least one req_valid is high, exactly one req_ready bit SHALL be high, chosen round-robin starting from requester (last_grant+1) mod NUM_REQ; otherwise req_ready SHALL be all zero.
REQ-017 req_ready SHALL NOT depend on req_valid of the same requester beyond the arbitration, and SHALL be combinational from req_valid, cdb_ready, flush and state.
REQ-018 The granted requester's fields SHALL drive the alu_* outputs combinationally in the same cycle; with no grant all alu_* outputs SHALL be zero (opcode 0 yields ALU result 0).
REQ-019 On an accepted request, the next clock edge SHALL load alu_result, alu_zero and the granted tag into cdb_result/cdb_zero/cdb_tag and set state FULL; latency is exactly one cycle from acceptance to cdb_valid.
REQ-020 In state FULL with cdb_ready=1 and no new acceptance, next state SHALL be EMPTY; with a simultaneous acceptance, state stays FULL with the new result (back-to-back throughput of one per cycle).
REQ-021 In state FULL with cdb_ready=0, cdb_valid, cdb_tag, cdb_result and cdb_zero SHALL hold stable and no grant SHALL be issued.
REQ-022 last_grant SHALL update only on an accepted request; it wraps from NUM_REQ-1 to 0.
REQ-023 flush=1 SHALL suppress grant that cycle and force state EMPTY at the next edge, discarding any held result; last_grant is retained.
REQ-024 Flush and cdb_ready high in the same cycle SHALL be treated as flush (result dropped, not counted as broadcast).

Reset
REQ-025 With rst_n=0 at a clock edge: state EMPTY, cdb_valid=0, cdb_tag=0, cdb_result=0, cdb_zero=0, last_grant=NUM_REQ-1 (requester 0 highest priority first), performance counters 0.
REQ-026 During reset, req_ready SHALL be all zero; reset asserted mid-transaction discards the held result.

Configuration
REQ-027 Macro ALU_ARB_PERF_EN, when defined, SHALL add outputs perf_issue_cnt (32) counting accepted requests and perf_stall_cnt (32) counting cycles with any req_valid high but no grant; both wrap at 2^32 and do not count during reset.
REQ-028 Without ALU_ARB_PERF_EN the perf ports and counters SHALL be absent and all other behaviour identical.

Structure
REQ-029 Opcode localparams (R, I, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR) and the EMPTY/FULL state encoding SHALL live in shared package alu_pkg, also used by the ALU.
REQ-030 The round-robin selector SHALL be a sub-module rr_arbiter (inputs req, pointer; output one-hot grant); the ALU itself is instantiated outside this block.

Verification
REQ-031 Reset then req_valid=4'b1111, cdb_ready=1 held: grants 0,1,2,3,0 on consecutive cycles; cdb_valid high from cycle 2 onward.
REQ-032 Requester 2 issues ADD (opcode 0110011, funct3 0, funct7 0) val_a=5 val_b=7 tag=9: next cycle cdb_valid=1, cdb_result=12, cdb_tag=9, cdb_zero=0.
REQ-033 Result held with cdb_ready=0 for 3 cycles while req_valid=4'b0011: req_ready=0 throughout, cdb outputs stable; cdb_ready=1 releases and grants the next requester in the same cycle.
REQ-034 BRANCH val_a=val_b=0x10 accepted, then flush=1 in the broadcast cycle: cdb_valid=0 next cycle, no broadcast, last_grant unchanged.
REQ-035 With ALU_ARB_PERF_EN: 10 accepts and 4 backpressure cycles with pending requests -> perf_issue_cnt=10, perf_stall_cnt=4; rst_n=0 mid-stream clears both and cdb_valid.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: RV32 major opcodes and the issue result-register state encoding.
package alu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot selector: searches from requester (pointer+1) mod NUM_REQ upward.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] pointer,
    output logic [NUM_REQ-1:0]         grant
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic             found;
    logic [PTR_W-1:0] idx;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PTR_W'((int'(pointer) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Issues one reservation-station request per cycle to the shared ALU and buffers its result for the CDB.
// Optional performance counters are enabled by defining ALU_ARB_PERF_EN.
module alu_issue_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*7-1:0]     req_opcode,
    input  logic [NUM_REQ*3-1:0]     req_funct3,
    input  logic [NUM_REQ*7-1:0]     req_funct7,
    input  logic [NUM_REQ*32-1:0]    req_val_a,
    input  logic [NUM_REQ*32-1:0]    req_val_b,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [6:0]               alu_opcode,
    output logic [2:0]               alu_funct3,
    output logic [6:0]               alu_funct7,
    output logic [31:0]              alu_val_a,
    output logic [31:0]              alu_val_b,
    input  logic [31:0]              alu_result,
    input  logic                     alu_zero,
    output logic                     cdb_valid,
    input  logic                     cdb_ready,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [31:0]              cdb_result,
    output logic                     cdb_zero
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]              perf_issue_cnt,
    output logic [31:0]              perf_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e         state, state_next;
    logic [PTR_W-1:0]   last_grant;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] rr_grant;
    logic [TAG_W-1:0]   grant_tag;
    logic               issue_ok;
    logic               accept;

    // Reset is folded in so no grant escapes while the block is held in reset.
    assign issue_ok = rst_n && !flush && (state == ST_EMPTY || cdb_ready);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .pointer (last_grant),
        .grant   (rr_grant)
    );

    assign req_ready = issue_ok ? rr_grant : '0;
    assign accept    = |req_ready;
    assign cdb_valid = (state == ST_FULL);

    // One-hot AND-OR mux; all fields read zero when nothing is granted.
    always_comb begin
        alu_opcode = '0;
        alu_funct3 = '0;
        alu_funct7 = '0;
        alu_val_a  = '0;
        alu_val_b  = '0;
        grant_tag  = '0;
        grant_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                alu_opcode = req_opcode[i*7 +: 7];
                alu_funct3 = req_funct3[i*3 +: 3];
                alu_funct7 = req_funct7[i*7 +: 7];
                alu_val_a  = req_val_a[i*32 +: 32];
                alu_val_b  = req_val_b[i*32 +: 32];
                grant_tag  = req_tag[i*TAG_W +: TAG_W];
                grant_idx  = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_EMPTY;
        end else if (accept) begin
            state_next = ST_FULL;
        end else if (state == ST_FULL && cdb_ready) begin
            state_next = ST_EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cdb_tag    <= '0;
            cdb_result <= '0;
            cdb_zero   <= 1'b0;
            last_grant <= PTR_W'(NUM_REQ - 1);
        end else if (accept) begin
            cdb_tag    <= grant_tag;
            cdb_result <= alu_result;
            cdb_zero   <= alu_zero;
            last_grant <= grant_idx;
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic stall;

    assign stall = (|req_valid) && !accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept) perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (stall)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: vector table for arbitration/backpressure plus hand sequences.
module tb_alu_issue_arbiter;
    import alu_pkg::*;

    localparam int N  = 4;
    localparam int TW = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*7-1:0]  req_opcode;
    logic [N*3-1:0]  req_funct3;
    logic [N*7-1:0]  req_funct7;
    logic [N*32-1:0] req_val_a;
    logic [N*32-1:0] req_val_b;
    logic [N*TW-1:0] req_tag;
    logic [6:0]      alu_opcode;
    logic [2:0]      alu_funct3;
    logic [6:0]      alu_funct7;
    logic [31:0]     alu_val_a;
    logic [31:0]     alu_val_b;
    logic [31:0]     alu_result;
    logic            alu_zero;
    logic            cdb_valid;
    logic            cdb_ready;
    logic [TW-1:0]   cdb_tag;
    logic [31:0]     cdb_result;
    logic            cdb_zero;
`ifdef ALU_ARB_PERF_EN
    logic [31:0]     perf_issue_cnt;
    logic [31:0]     perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    alu_issue_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_val_a  (req_val_a),
        .req_val_b  (req_val_b),
        .req_tag    (req_tag),
        .alu_opcode (alu_opcode),
        .alu_funct3 (alu_funct3),
        .alu_funct7 (alu_funct7),
        .alu_val_a  (alu_val_a),
        .alu_val_b  (alu_val_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .cdb_valid  (cdb_valid),
        .cdb_ready  (cdb_ready),
        .cdb_tag    (cdb_tag),
        .cdb_result (cdb_result),
        .cdb_zero   (cdb_zero)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Minimal ALU stand-in: opcode 0 gives 0, SUB/BRANCH subtract, everything else adds.
    always_comb begin
        if (alu_opcode == 7'd0)
            alu_result = 32'd0;
        else if ((alu_opcode == OP_R && alu_funct7[5]) || alu_opcode == OP_BRANCH)
            alu_result = alu_val_a - alu_val_b;
        else
            alu_result = alu_val_a + alu_val_b;
        alu_zero = (alu_result == 32'd0);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                           input logic [TW-1:0] tag);
        req_opcode[i*7 +: 7]   = op;
        req_funct3[i*3 +: 3]   = f3;
        req_funct7[i*7 +: 7]   = f7;
        req_val_a[i*32 +: 32]  = a;
        req_val_b[i*32 +: 32]  = b;
        req_tag[i*TW +: TW]    = tag;
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        cdb_ready = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          flush;
        logic [N-1:0]  valid;
        logic          rdy;
        logic [N-1:0]  exp_ready;
        logic          exp_cv;
        logic [TW-1:0] exp_tag;
        logic [31:0]   exp_result;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] exp_a;

        // Requester i: ADD (100+i) + i, tag i+1 -> result 100+2i.
        vecs[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 6'd0, 32'd0};
        vecs[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 6'd1, 32'd100};
        vecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 6'd2, 32'd102};
        vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 6'd3, 32'd104};
        vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 6'd4, 32'd106};
        vecs[5]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 6'd1, 32'd100};
        vecs[6]  = '{1'b0, 4'b0110, 1'b0, 4'b0000, 1'b1, 6'd1, 32'd100};
        vecs[7]  = '{1'b0, 4'b0110, 1'b1, 4'b0010, 1'b1, 6'd1, 32'd100};
        vecs[8]  = '{1'b0, 4'b0110, 1'b1, 4'b0100, 1'b1, 6'd2, 32'd102};
        vecs[9]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 6'd3, 32'd104};
        vecs[10] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 1'b0, 6'd3, 32'd104};
        vecs[11] = '{1'b1, 4'b1001, 1'b0, 4'b0000, 1'b1, 6'd4, 32'd106};
        vecs[12] = '{1'b0, 4'b1001, 1'b1, 4'b0001, 1'b0, 6'd4, 32'd106};
        vecs[13] = '{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1, 6'd1, 32'd100};

        req_opcode = '0; req_funct3 = '0; req_funct7 = '0;
        req_val_a  = '0; req_val_b  = '0; req_tag    = '0;
        for (int i = 0; i < N; i++)
            set_req(i, OP_R, 3'd0, 7'd0, 32'(100 + i), 32'(i), TW'(i + 1));

        reset_dut();
        for (int v = 0; v < 14; v++) begin
            flush     = vecs[v].flush;
            req_valid = vecs[v].valid;
            cdb_ready = vecs[v].rdy;
            @(negedge clk);
            exp_a = 32'd0;
            for (int i = 0; i < N; i++)
                if (vecs[v].exp_ready[i]) exp_a = 32'(100 + i);
            check($sformatf("vec%0d req_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
            check($sformatf("vec%0d alu_val_a", v), alu_val_a, exp_a);
            check($sformatf("vec%0d cdb_valid", v), 32'(cdb_valid), 32'(vecs[v].exp_cv));
            check($sformatf("vec%0d cdb_tag", v), 32'(cdb_tag), 32'(vecs[v].exp_tag));
            check($sformatf("vec%0d cdb_result", v), cdb_result, vecs[v].exp_result);
            next_cycle();
        end

        // ADD from requester 2, one-cycle latency to the CDB.
        reset_dut();
        set_req(2, OP_R, 3'd0, 7'd0, 32'd5, 32'd7, 6'd9);
        set_req(0, OP_R, 3'd0, 7'd0, 32'd1, 32'd2, 6'd20);
        set_req(1, OP_R, 3'd0, 7'd0, 32'd3, 32'd4, 6'd21);
        req_valid = 4'b0100;
        cdb_ready = 1'b1;
        @(negedge clk);
        check("add reset_cdb_valid", 32'(cdb_valid), 32'd0);
        check("add req_ready", 32'(req_ready), 32'b0100);
        check("add alu_opcode", 32'(alu_opcode), 32'(OP_R));
        next_cycle();

        // Backpressure for three cycles, then release grants requester 0 in the same cycle.
        req_valid = 4'b0011;
        cdb_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d req_ready", c), 32'(req_ready), 32'd0);
            check($sformatf("hold%0d cdb_valid", c), 32'(cdb_valid), 32'd1);
            check($sformatf("hold%0d cdb_result", c), cdb_result, 32'd12);
            check($sformatf("hold%0d cdb_tag", c), 32'(cdb_tag), 32'd9);
            check($sformatf("hold%0d cdb_zero", c), 32'(cdb_zero), 32'd0);
            next_cycle();
        end
        cdb_ready = 1'b1;
        @(negedge clk);
        check("release req_ready", 32'(req_ready), 32'b0001);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("release cdb_tag", 32'(cdb_tag), 32'd20);
        check("release cdb_result", cdb_result, 32'd3);
        next_cycle();

        // BRANCH with equal operands, then flush during its broadcast cycle.
        set_req(1, OP_BRANCH, 3'd0, 7'd0, 32'h10, 32'h10, 6'd5);
        req_valid = 4'b0010;
        cdb_ready = 1'b0;
        @(negedge clk);
        check("branch req_ready", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid = '0;
        flush     = 1'b1;
        cdb_ready = 1'b1;
        @(negedge clk);
        check("branch cdb_valid", 32'(cdb_valid), 32'd1);
        check("branch cdb_zero", 32'(cdb_zero), 32'd1);
        check("branch cdb_tag", 32'(cdb_tag), 32'd5);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("flush cdb_valid", 32'(cdb_valid), 32'd0);
        next_cycle();
        req_valid = 4'b1111;
        @(negedge clk);
        check("post_flush req_ready", 32'(req_ready), 32'b0100);
        next_cycle();

        // Reset with a held result discards it and restores requester-0 priority.
        rst_n = 1'b0;
        @(negedge clk);
        check("in_reset req_ready", 32'(req_ready), 32'd0);
        next_cycle();
        rst_n     = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("mid_reset cdb_valid", 32'(cdb_valid), 32'd0);
        check("mid_reset cdb_tag", 32'(cdb_tag), 32'd0);
        check("mid_reset cdb_result", cdb_result, 32'd0);
        next_cycle();
        req_valid = 4'b1111;
        @(negedge clk);
        check("mid_reset req_ready", 32'(req_ready), 32'b0001);
        next_cycle();

`ifdef ALU_ARB_PERF_EN
        reset_dut();
        req_valid = 4'b0001;
        cdb_ready = 1'b1;
        repeat (10) next_cycle();
        cdb_ready = 1'b0;
        repeat (4) next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("perf_issue_cnt", perf_issue_cnt, 32'd10);
        check("perf_stall_cnt", perf_stall_cnt, 32'd4);
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("perf_issue_cnt reset", perf_issue_cnt, 32'd0);
        check("perf_stall_cnt reset", perf_stall_cnt, 32'd0);
        check("perf cdb_valid reset", 32'(cdb_valid), 32'd0);
        next_cycle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
